// File: rtl/truth_table_capture_if.sv
// Sample/result bundle between a truth-table driver and the capture stage.
interface truth_table_capture_if;
  logic        start;
  logic        sample_valid;
  logic [3:0]  sample_m;
  logic        sample_q;
  logic        busy;
  logic        done;
  logic        match;
  logic        conflict;
  logic        timeout;
  logic [15:0] table_q;
  logic [15:0] seen;
  logic [15:0] mismatch;
  logic [4:0]  count;

  // Driver side: issues start and samples, observes results.
  modport master (
    output start, sample_valid, sample_m, sample_q,
    input  busy, done, match, conflict, timeout, table_q, seen, mismatch, count
  );

  // Capture side.
  modport slave (
    input  start, sample_valid, sample_m, sample_q,
    output busy, done, match, conflict, timeout, table_q, seen, mismatch, count
  );
endinterface

// File: rtl/truth_table_capture.sv
// Captures one (minterm, q) sample per cycle into a 16-entry table, then
// compares the table with EXPECTED once every minterm has been seen.
// A stall of TIMEOUT idle cycles aborts the capture straight into DONE.
module truth_table_capture #(
  parameter logic [15:0] EXPECTED = 16'h6EEE,
  parameter int          TIMEOUT  = 64
) (
  input logic                   i_clk,
  input logic                   i_clr,
  truth_table_capture_if.slave  bus
);

  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_table, r_seen, r_mismatch;
  logic [4:0]    r_count;
  logic          r_conflict, r_timeout, r_match;
  logic [IW-1:0] r_idle;

  logic [15:0]   w_seen_nxt;
  logic [15:0]   w_mis;
  logic          w_stall_out;

  // Coverage including this cycle's write, so the last sample exits COLLECT at once.
  always_comb begin
    w_seen_nxt = r_seen;
    if (bus.sample_valid) w_seen_nxt[bus.sample_m] = 1'b1;
  end

  assign w_mis       = (r_table ^ EXPECTED) & r_seen;
  assign w_stall_out = !bus.sample_valid && (r_idle == IDLE_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_clr) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; start restarts the capture from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = COLLECT;
      COLLECT: begin
        if (bus.start)                                       w_state_nxt = COLLECT;
        else if (bus.sample_valid && (&w_seen_nxt))          w_state_nxt = CHECK;
        else if (w_stall_out)                                w_state_nxt = DONE;
      end
      CHECK:   w_state_nxt = bus.start ? COLLECT : DONE;
      DONE:    if (bus.start) w_state_nxt = COLLECT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture datapath: table fill, conflict/timeout flags and final compare.
  always_ff @(posedge i_clk) begin
    if (i_clr || bus.start) begin
      // A sample arriving alongside start is deliberately dropped.
      r_table    <= '0;
      r_seen     <= '0;
      r_count    <= '0;
      r_conflict <= 1'b0;
      r_timeout  <= 1'b0;
      r_mismatch <= '0;
      r_match    <= 1'b0;
      r_idle     <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (bus.sample_valid) begin
            r_table[bus.sample_m] <= bus.sample_q;
            r_seen[bus.sample_m]  <= 1'b1;
            if (!r_seen[bus.sample_m])
              r_count <= r_count + 5'd1;
            else if (r_table[bus.sample_m] != bus.sample_q)
              r_conflict <= 1'b1;
            r_idle <= '0;
          end else if (w_stall_out) begin
            // Aborted capture still reports which seen entries disagree.
            r_timeout  <= 1'b1;
            r_mismatch <= w_mis;
            r_match    <= 1'b0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        CHECK: begin
          r_mismatch <= w_mis;
          r_match    <= (w_mis == '0) && !r_conflict && !r_timeout;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == COLLECT) || (r_state == CHECK);
  assign bus.done     = (r_state == DONE);
  assign bus.match    = r_match;
  assign bus.conflict = r_conflict;
  assign bus.timeout  = r_timeout;
  assign bus.table_q  = r_table;
  assign bus.seen     = r_seen;
  assign bus.mismatch = r_mismatch;
  assign bus.count    = r_count;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed stimulus for truth_table_capture; expected results are queued
// when a capture is issued and checked by a monitor when done rises.
module tb_truth_table_capture;

  localparam logic [15:0] EXP = 16'h6EEE;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  truth_table_capture_if bus();

  truth_table_capture #(.EXPECTED(EXP), .TIMEOUT(64)) dut (
    .i_clk (clk),
    .i_clr (clr),
    .bus   (bus)
  );

  typedef struct {
    logic        match, conflict, timeout;
    logic [15:0] tbl, seen, mis;
    logic [4:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one queued expectation per rising edge of done.
  initial begin
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !pd) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done rose at cycle %0d with empty scoreboard", cyc);
        end else begin
          e = sb.pop_front();
          chk("match",    32'(bus.match),    32'(e.match));
          chk("conflict", 32'(bus.conflict), 32'(e.conflict));
          chk("timeout",  32'(bus.timeout),  32'(e.timeout));
          chk("table_q",  32'(bus.table_q),  32'(e.tbl));
          chk("seen",     32'(bus.seen),     32'(e.seen));
          chk("mismatch", 32'(bus.mismatch), 32'(e.mis));
          chk("count",    32'(bus.count),    32'(e.cnt));
          chk("done_cycle", cyc, e.cyc);
        end
      end
      pd = bus.done;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int m, input logic q);
    bus.sample_valid = 1'b1;
    bus.sample_m     = 4'(m);
    bus.sample_q     = q;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Minterms 0..15 in order with correct q, flipped where flip is set, skipped where skip is set.
  task automatic full(input logic [15:0] flip, input logic [15:0] skip);
    for (int m = 0; m < 16; m++)
      if (!skip[m]) smp(m, EXP[m] ^ flip[m]);
  endtask

  task automatic push(input logic mt, input logic cf, input logic to, input logic [15:0] tbl,
                      input logic [15:0] sn, input logic [15:0] mis, input logic [4:0] cnt,
                      input int c);
    exp_t e;
    e.match = mt; e.conflict = cf; e.timeout = to;
    e.tbl = tbl; e.seen = sn; e.mis = mis; e.cnt = cnt; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    if (!bus.done) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: done not seen within %0d cycles", budget);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_m = '0;
    bus.sample_q = 1'b0;
    step();
    step();
    chk("rst_busy",     32'(bus.busy),     0);
    chk("rst_done",     32'(bus.done),     0);
    chk("rst_match",    32'(bus.match),    0);
    chk("rst_conflict", 32'(bus.conflict), 0);
    chk("rst_timeout",  32'(bus.timeout),  0);
    chk("rst_table",    32'(bus.table_q),  0);
    chk("rst_seen",     32'(bus.seen),     0);
    chk("rst_mismatch", 32'(bus.mismatch), 0);
    chk("rst_count",    32'(bus.count),    0);
    clr = 1'b0;
    step();

    // 1: clean full sequence
    do_start();
    chk("start_busy", 32'(bus.busy), 1);
    full(16'h0000, 16'h0000);
    push(1'b1, 1'b0, 1'b0, 16'h6EEE, 16'hFFFF, 16'h0000, 5'd16, cyc + 1);
    wait_done(10);

    // 2: minterm 15 wrong
    do_start();
    full(16'h8000, 16'h0000);
    push(1'b0, 1'b0, 1'b0, 16'hEEEE, 16'hFFFF, 16'h8000, 5'd16, cyc + 1);
    wait_done(10);

    // 3: conflict on minterm 5, last value (0) kept
    do_start();
    smp(5, 1'b1);
    smp(5, 1'b0);
    full(16'h0000, 16'h0020);
    push(1'b0, 1'b1, 1'b0, 16'h6ECE, 16'hFFFF, 16'h0020, 5'd16, cyc + 1);
    wait_done(10);

    // 4: stall after ten minterms
    do_start();
    for (int m = 0; m < 10; m++) smp(m, EXP[m]);
    push(1'b0, 1'b0, 1'b1, 16'h02EE, 16'h03FF, 16'h0000, 5'd10, cyc + 64);
    wait_done(80);

    // 5: clear mid-capture, then clean run
    do_start();
    for (int m = 0; m < 8; m++) smp(m, EXP[m]);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_busy",  32'(bus.busy),  0);
    chk("clr_seen",  32'(bus.seen),  0);
    chk("clr_done",  32'(bus.done),  0);
    do_start();
    full(16'h0000, 16'h0000);
    push(1'b1, 1'b0, 1'b0, 16'h6EEE, 16'hFFFF, 16'h0000, 5'd16, cyc + 1);
    wait_done(10);

    // 6: restart during COLLECT with a concurrent sample
    do_start();
    for (int m = 0; m < 12; m++) smp(m, EXP[m]);
    chk("pre_restart_count", 32'(bus.count), 12);
    bus.start = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_m = 4'd12;
    bus.sample_q = 1'b0;
    step();
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    chk("restart_seen",  32'(bus.seen),    0);
    chk("restart_count", 32'(bus.count),   0);
    chk("restart_table", 32'(bus.table_q), 0);
    chk("restart_busy",  32'(bus.busy),    1);
    full(16'h0000, 16'h0000);
    push(1'b1, 1'b0, 1'b0, 16'h6EEE, 16'hFFFF, 16'h0000, 5'd16, cyc + 1);
    wait_done(10);

    step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
